pic_control_logic: RTL and testbench

Clocked control sequencer for the 8259A-compatible PIC, between the bus interface and the priority/in-service datapath. It decodes completed CPU write cycles into ICW1–ICW4 and OCW1–OCW3 and tracks the initialization sequence in an FSM. It holds the configuration and mask registers and runs the two-pulse 8086 INTA handshake that places the interrupt vector on the data bus.

---
 rtl/pic_pkg.sv | 29 ++
 rtl/pic_inta_sequencer.sv | 102 ++++++++++
 rtl/pic_control_logic.sv | 190 +++++++++++++++++++
 tb/tb_pic_control_logic.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A-compatible PIC control path.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    READY
  } init_state_e;

  typedef enum logic [1:0] {
    I_IDLE,
    I_ACK1,
    I_ACK2
  } inta_state_e;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;
  localparam int OCW3_SEL  = 3;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;
  localparam int ICW4_AEOI = 1;

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

endpackage

// File: rtl/pic_inta_sequencer.sv
// 8086-mode two-pulse INTA handshake: edge detection, level latch and vector drive.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inta_n,
  input  logic       init_done,
  input  logic       abort,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  output logic       ack1,
  output logic       ack2,
  output logic       eoi_auto,
  output logic [7:0] vector_out,
  output logic       vector_oe
);

  inta_state_e state_q, state_d;
  logic       inta_q;
  logic [2:0] lvl_q, lvl_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_oe_q, vector_oe_d;
  logic       ack1_q, ack1_d;
  logic       ack2_q, ack2_d;
  logic       eoi_q, eoi_d;
  logic       inta_fall, inta_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= I_IDLE;
      inta_q       <= 1'b1;
      lvl_q        <= 3'd0;
      vector_out_q <= 8'h00;
      vector_oe_q  <= 1'b0;
      ack1_q       <= 1'b0;
      ack2_q       <= 1'b0;
      eoi_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      inta_q       <= inta_n;
      lvl_q        <= lvl_d;
      vector_out_q <= vector_out_d;
      vector_oe_q  <= vector_oe_d;
      ack1_q       <= ack1_d;
      ack2_q       <= ack2_d;
      eoi_q        <= eoi_d;
    end
  end

  // An ICW1 commit on the same edge as an INTA edge wins: the handshake is dropped silently.
  always_comb begin
    inta_fall    = ~inta_n & inta_q;
    inta_rise    = inta_n & ~inta_q;
    state_d      = state_q;
    lvl_d        = lvl_q;
    vector_out_d = vector_out_q;
    vector_oe_d  = vector_oe_q;
    ack1_d       = 1'b0;
    ack2_d       = 1'b0;
    eoi_d        = 1'b0;
    if (abort || !init_done) begin
      state_d     = I_IDLE;
      vector_oe_d = 1'b0;
    end else begin
      case (state_q)
        I_IDLE: begin
          if (inta_fall) begin
            ack1_d  = 1'b1;
            lvl_d   = int_req ? int_level : SPURIOUS_LEVEL;
            state_d = I_ACK1;
          end
        end
        I_ACK1: begin
          if (inta_fall) begin
            ack2_d       = 1'b1;
            vector_oe_d  = 1'b1;
            vector_out_d = {vector_base, lvl_q};
            state_d      = I_ACK2;
          end
        end
        I_ACK2: begin
          if (inta_rise) begin
            vector_oe_d = 1'b0;
            eoi_d       = aeoi;
            state_d     = I_IDLE;
          end
        end
        default: state_d = I_IDLE;
      endcase
    end
  end

  assign ack1       = ack1_q;
  assign ack2       = ack2_q;
  assign eoi_auto   = eoi_q;
  assign vector_out = vector_out_q;
  assign vector_oe  = vector_oe_q;

endmodule

// File: rtl/pic_control_logic.sv
// PIC control sequencer: decodes committed CPU writes into ICW/OCW words, tracks
// initialization and hands the INTA handshake to pic_inta_sequencer.
module pic_control_logic
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] int_level,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       aeoi,
  output logic [7:0] icw3,
  output logic [4:0] vector_base,
  output logic [7:0] imr,
  output logic       ocw2_strobe,
  output logic [7:0] ocw2_data,
  output logic [1:0] rr_ris,
  output logic       smm,
  output logic       int_out,
  output logic       ack1,
  output logic       ack2,
  output logic       eoi_auto,
  output logic [7:0] vector_out,
  output logic       vector_oe
);

  init_state_e state_q, state_d;
  logic       wr_q, cs_q;
  logic [7:0] wdata_q, wdata_d;
  logic       wa0_q, wa0_d;
  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       aeoi_q, aeoi_d;
  logic [7:0] icw3_q, icw3_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] imr_q, imr_d;
  logic       ocw2_strobe_q, ocw2_strobe_d;
  logic [7:0] ocw2_data_q, ocw2_data_d;
  logic [1:0] rr_ris_q, rr_ris_d;
  logic       smm_q, smm_d;
  logic       commit, icw1_commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= UNINIT;
      wr_q          <= 1'b1;
      cs_q          <= 1'b1;
      wdata_q       <= 8'h00;
      wa0_q         <= 1'b0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      aeoi_q        <= 1'b0;
      icw3_q        <= 8'h00;
      vector_base_q <= 5'h00;
      imr_q         <= 8'h00;
      ocw2_strobe_q <= 1'b0;
      ocw2_data_q   <= 8'h00;
      rr_ris_q      <= 2'b10;
      smm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_n;
      cs_q          <= cs_n;
      wdata_q       <= wdata_d;
      wa0_q         <= wa0_d;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      aeoi_q        <= aeoi_d;
      icw3_q        <= icw3_d;
      vector_base_q <= vector_base_d;
      imr_q         <= imr_d;
      ocw2_strobe_q <= ocw2_strobe_d;
      ocw2_data_q   <= ocw2_data_d;
      rr_ris_q      <= rr_ris_d;
      smm_q         <= smm_d;
    end
  end

  // A write commits on the first cycle wr_n is seen high after a cycle with both strobes low.
  always_comb begin
    commit        = wr_n & ~wr_q & ~cs_q;
    icw1_commit   = commit & ~wa0_q & wdata_q[ICW1_SEL];
    state_d       = state_q;
    wdata_d       = wdata_q;
    wa0_d         = wa0_q;
    ltim_d        = ltim_q;
    sngl_d        = sngl_q;
    ic4_d         = ic4_q;
    aeoi_d        = aeoi_q;
    icw3_d        = icw3_q;
    vector_base_d = vector_base_q;
    imr_d         = imr_q;
    ocw2_strobe_d = 1'b0;
    ocw2_data_d   = ocw2_data_q;
    rr_ris_d      = rr_ris_q;
    smm_d         = smm_q;

    if (!cs_n && !wr_n) begin
      wdata_d = data_in;
      wa0_d   = a0;
    end

    if (icw1_commit) begin
      ltim_d   = wdata_q[ICW1_LTIM];
      sngl_d   = wdata_q[ICW1_SNGL];
      ic4_d    = wdata_q[ICW1_IC4];
      imr_d    = 8'h00;
      smm_d    = 1'b0;
      aeoi_d   = 1'b0;
      rr_ris_d = 2'b10;
      state_d  = W_ICW2;
    end else if (commit) begin
      case (state_q)
        W_ICW2: begin
          if (wa0_q) begin
            vector_base_d = wdata_q[7:3];
            if (!sngl_q)    state_d = W_ICW3;
            else if (ic4_q) state_d = W_ICW4;
            else            state_d = READY;
          end
        end
        W_ICW3: begin
          if (wa0_q) begin
            icw3_d  = wdata_q;
            state_d = ic4_q ? W_ICW4 : READY;
          end
        end
        W_ICW4: begin
          if (wa0_q) begin
            aeoi_d  = wdata_q[ICW4_AEOI];
            state_d = READY;
          end
        end
        READY: begin
          if (wa0_q) begin
            imr_d = wdata_q;
          end else if (!wdata_q[OCW3_SEL]) begin
            ocw2_data_d   = wdata_q;
            ocw2_strobe_d = 1'b1;
          end else begin
            if (wdata_q[1])         rr_ris_d = wdata_q[1:0];
            if (wdata_q[OCW3_ESMM]) smm_d    = wdata_q[OCW3_SMM];
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done   = (state_q == READY);
  assign ltim        = ltim_q;
  assign sngl        = sngl_q;
  assign aeoi        = aeoi_q;
  assign icw3        = icw3_q;
  assign vector_base = vector_base_q;
  assign imr         = imr_q;
  assign ocw2_strobe = ocw2_strobe_q;
  assign ocw2_data   = ocw2_data_q;
  assign rr_ris      = rr_ris_q;
  assign smm         = smm_q;
  assign int_out     = int_req & init_done;

  pic_inta_sequencer u_inta (
    .clk         (clk),
    .reset       (reset),
    .inta_n      (inta_n),
    .init_done   (init_done),
    .abort       (icw1_commit),
    .int_req     (int_req),
    .int_level   (int_level),
    .vector_base (vector_base_q),
    .aeoi        (aeoi_q),
    .ack1        (ack1),
    .ack2        (ack2),
    .eoi_auto    (eoi_auto),
    .vector_out  (vector_out),
    .vector_oe   (vector_oe)
  );

endmodule

// File: tb/tb_pic_control_logic.sv
// Scoreboard bench for pic_control_logic: a word-sequence reference model predicts
// register contents and the pulse/vector events a monitor collects from the DUT.
module tb_pic_control_logic;

  logic       clock = 1'b0;
  logic       reset;
  logic       csN, wrN, a0, intaN, intReq;
  logic [7:0] dataIn;
  logic [2:0] intLevel;
  logic       initDone, ltim, sngl, aeoi, ocw2Strobe, smm, intOut;
  logic       ack1, ack2, eoiAuto, vectorOe;
  logic [7:0] icw3, imr, ocw2Data, vectorOut;
  logic [4:0] vectorBase;
  logic [1:0] rrRis;

  always #5 clock = ~clock;

  pic_control_logic dut (
    .clk         (clock),
    .reset       (reset),
    .cs_n        (csN),
    .wr_n        (wrN),
    .a0          (a0),
    .data_in     (dataIn),
    .inta_n      (intaN),
    .int_req     (intReq),
    .int_level   (intLevel),
    .init_done   (initDone),
    .ltim        (ltim),
    .sngl        (sngl),
    .aeoi        (aeoi),
    .icw3        (icw3),
    .vector_base (vectorBase),
    .imr         (imr),
    .ocw2_strobe (ocw2Strobe),
    .ocw2_data   (ocw2Data),
    .rr_ris      (rrRis),
    .smm         (smm),
    .int_out     (intOut),
    .ack1        (ack1),
    .ack2        (ack2),
    .eoi_auto    (eoiAuto),
    .vector_out  (vectorOut),
    .vector_oe   (vectorOe)
  );

  // Event kinds: 0 OCW2 strobe, 1 ack1, 2 ack2, 3 auto-EOI, 4 vector_oe rise
  typedef struct {
    int         kind;
    logic [8:0] data;
  } event_t;

  event_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Reference model: ICW1 opens a list of still-expected init words; empty list means ready
  bit         mConfigured;
  int         mPending[$];
  bit         mLtim, mSngl, mIc4, mAeoi, mSmm;
  logic [7:0] mImr, mIcw3;
  logic [4:0] mBase;
  logic [1:0] mRrRis;
  int         mIntaPhase;
  logic [2:0] mLvl;

  function automatic bit mInitDone();
    return mConfigured && (mPending.size() == 0);
  endfunction

  task automatic pushEvent(input int kind, input logic [8:0] data);
    event_t e;
    e.kind = kind;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic modelReset();
    mConfigured = 0;
    mPending.delete();
    {mLtim, mSngl, mIc4, mAeoi, mSmm} = '0;
    mImr = 8'h00;
    mIcw3 = 8'h00;
    mBase = 5'h00;
    mRrRis = 2'b10;
    mIntaPhase = 0;
    mLvl = 3'd0;
  endtask

  task automatic modelWrite(input bit wa0, input logic [7:0] d);
    if (!wa0 && d[4]) begin
      mLtim = d[3];
      mSngl = d[1];
      mIc4 = d[0];
      mImr = 8'h00;
      mSmm = 0;
      mAeoi = 0;
      mRrRis = 2'b10;
      mConfigured = 1;
      mIntaPhase = 0;
      mPending.delete();
      mPending.push_back(2);
      if (!mSngl) mPending.push_back(3);
      if (mIc4) mPending.push_back(4);
    end else if (!mConfigured) begin
    end else if (mPending.size() > 0) begin
      if (wa0) begin
        case (mPending[0])
          2: mBase = d[7:3];
          3: mIcw3 = d;
          default: mAeoi = d[1];
        endcase
        void'(mPending.pop_front());
      end
    end else if (wa0) begin
      mImr = d;
    end else if (!d[3]) begin
      pushEvent(0, {1'b0, d});
    end else begin
      if (d[1]) mRrRis = d[1:0];
      if (d[6]) mSmm = d[5];
    end
  endtask

  task automatic modelFall();
    if (mInitDone()) begin
      if (mIntaPhase == 0) begin
        mLvl = intReq ? intLevel : 3'd7;
        pushEvent(1, 9'h000);
        mIntaPhase = 1;
      end else if (mIntaPhase == 1) begin
        pushEvent(2, {1'b1, mBase, mLvl});
        pushEvent(4, {1'b0, mBase, mLvl});
        mIntaPhase = 2;
      end
    end
  endtask

  task automatic modelRise();
    if (mInitDone() && mIntaPhase == 2) begin
      if (mAeoi) pushEvent(3, 9'h000);
      mIntaPhase = 0;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    cmp("init_done", 32'(initDone), 32'(mInitDone()));
    cmp("imr", 32'(imr), 32'(mImr));
    cmp("rr_ris", 32'(rrRis), 32'(mRrRis));
    cmp("smm", 32'(smm), 32'(mSmm));
    cmp("aeoi", 32'(aeoi), 32'(mAeoi));
    cmp("vector_base", 32'(vectorBase), 32'(mBase));
    cmp("icw3", 32'(icw3), 32'(mIcw3));
    cmp("ltim", 32'(ltim), 32'(mLtim));
    cmp("sngl", 32'(sngl), 32'(mSngl));
    cmp("int_out", 32'(intOut), 32'(intReq & mInitDone()));
  endtask

  task automatic checkEvent(input int kind, input logic [8:0] data, input string name);
    event_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s unexpected actual data=%0h required no event", name, data);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.data !== data) begin
        errors++;
        $display("[TB] FAIL %s actual kind=%0d data=%0h required kind=%0d data=%0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every output pulse or vector_oe rise must match the head of the expected queue
  initial begin
    logic prevOe;
    prevOe = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (ack1) checkEvent(1, 9'h000, "ack1");
        if (ack2) checkEvent(2, {vectorOe, vectorOut}, "ack2");
        if (vectorOe && !prevOe) checkEvent(4, {1'b0, vectorOut}, "vector_oe_rise");
        if (ocw2Strobe) checkEvent(0, {1'b0, ocw2Data}, "ocw2_strobe");
        if (eoiAuto) checkEvent(3, {vectorOe, 8'h00}, "eoi_auto");
      end
      prevOe = vectorOe;
    end
  end

  // Bus write: two cycles with strobes low, then both released; commit lands on the next edge
  task automatic applyStimulus(input bit wa0, input logic [7:0] d, input bit fallTogether = 1'b0);
    @(posedge clock); #1;
    csN = 0; wrN = 0; a0 = wa0; dataIn = d;
    @(posedge clock); #1;
    @(posedge clock); #1;
    wrN = 1; csN = 1; a0 = 1'($urandom); dataIn = 8'($urandom);
    if (fallTogether) intaN = 0;
    modelWrite(wa0, d);
    if (fallTogether) modelFall();
    @(posedge clock); #1;
    checkOutput();
  endtask

  task automatic intaPulse(input bit req, input logic [2:0] lvl);
    @(posedge clock); #1;
    intReq = req; intLevel = lvl; intaN = 0;
    modelFall();
    @(posedge clock); #1;
    @(posedge clock); #1;
    cmp("vector_oe_low_phase", 32'(vectorOe), 32'(mIntaPhase == 2));
    intaN = 1;
    modelRise();
    @(posedge clock); #1;
    cmp("vector_oe_after_rise", 32'(vectorOe), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic doReset();
    reset = 1;
    modelReset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic randomInit();
    logic [7:0] w1;
    w1 = 8'(($urandom & 32'hEF) | 32'h10);
    applyStimulus(0, w1);
    applyStimulus(1, 8'($urandom));
    if (!w1[1]) applyStimulus(1, 8'($urandom));
    if (w1[0]) applyStimulus(1, 8'($urandom));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    csN = 1; wrN = 1; a0 = 0; dataIn = 8'h00;
    intaN = 1; intReq = 1; intLevel = 3'd0;
    reset = 0;
    #2 doReset();
    @(posedge clock); #1;
    checkOutput();
    cmp("reset_vector_oe", 32'(vectorOe), 32'd0);
    cmp("reset_vector_out", 32'(vectorOut), 32'h00);

    // Writes before ICW1 are ignored
    applyStimulus(1, 8'hA5);
    applyStimulus(0, 8'h20);

    // Single mode with ICW4: ICW3 skipped
    applyStimulus(0, 8'h13);
    applyStimulus(1, 8'h48);
    applyStimulus(1, 8'h03);
    cmp("base_09", 32'(vectorBase), 32'h09);

    // Cascade mode: all four words, then a mask write
    applyStimulus(0, 8'h11);
    applyStimulus(1, 8'h20);
    applyStimulus(1, 8'h04);
    applyStimulus(1, 8'h01);
    applyStimulus(1, 8'hFB);
    cmp("imr_FB", 32'(imr), 32'hFB);

    // Strobes released out of order: cs_n high before wr_n rises is not a commit
    @(posedge clock); #1;
    csN = 0; wrN = 0; a0 = 1; dataIn = 8'h3C;
    @(posedge clock); #1;
    csN = 1;
    @(posedge clock); #1;
    wrN = 1;
    repeat (2) @(posedge clock); #1;
    checkOutput();

    // Base 08h with auto-EOI, real and spurious acknowledges
    applyStimulus(0, 8'h13);
    applyStimulus(1, 8'h08);
    applyStimulus(1, 8'h03);
    intaPulse(1, 3'd5);
    intaPulse(1, 3'd5);
    intaPulse(0, 3'd2);
    intaPulse(0, 3'd2);

    // OCW3 and OCW2
    applyStimulus(0, 8'h6B);
    applyStimulus(0, 8'h20);

    // ICW1 mid-init and between INTA pulses
    applyStimulus(0, 8'h13);
    applyStimulus(1, 8'h08);
    applyStimulus(0, 8'h17);
    applyStimulus(1, 8'h50);
    applyStimulus(1, 8'h01);
    applyStimulus(1, 8'h0F);
    intaPulse(1, 3'd3);
    applyStimulus(0, 8'h13);
    intaPulse(1, 3'd3);
    applyStimulus(1, 8'h08);
    applyStimulus(1, 8'h02);

    // ICW1 commit coincident with the second INTA falling edge
    intaPulse(1, 3'd1);
    applyStimulus(0, 8'h13, 1'b1);
    @(posedge clock); #1;
    intaN = 1;
    modelRise();
    repeat (2) @(posedge clock); #1;
    cmp("vector_oe_after_abort", 32'(vectorOe), 32'd0);

    // Randomized traffic
    for (int round = 0; round < 6; round++) begin
      randomInit();
      for (int k = 0; k < 25; k++) begin
        case ($urandom_range(0, 4))
          0: applyStimulus(1, 8'($urandom));
          1: applyStimulus(0, 8'($urandom & 32'hE7));
          2: applyStimulus(0, 8'(($urandom & 32'hE7) | 32'h08));
          default: intaPulse(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        endcase
      end
    end

    // Reset during the vector phase drops vector_oe without waiting for a clock
    applyStimulus(0, 8'h13);
    applyStimulus(1, 8'h08);
    applyStimulus(1, 8'h01);
    intaPulse(1, 3'd6);
    @(posedge clock); #1;
    intReq = 1; intLevel = 3'd6; intaN = 0;
    modelFall();
    repeat (2) @(posedge clock); #1;
    cmp("vector_oe_before_reset", 32'(vectorOe), 32'd1);
    @(negedge clock); #2;
    reset = 1;
    #1;
    cmp("vector_oe_async_reset", 32'(vectorOe), 32'd0);
    cmp("queue_empty_before_reset", 32'(expQ.size()), 32'd0);
    modelReset();
    repeat (2) @(posedge clock);
    #1 intaN = 1;
    reset = 0;
    @(posedge clock); #1;
    checkOutput();

    repeat (4) @(posedge clock); #1;
    cmp("queue_empty_end", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
